hdmi_data_island_decoder: RTL and testbench

HDMI_DATA_ISLAND_DECODER -- requirements
Module: hdmi_data_island_decoder

---
 rtl/hdmi_island_pkg.sv | 29 ++
 rtl/hdmi_bch8_step.sv | 24 ++
 rtl/hdmi_data_island_decoder.sv | 203 ++++++++++++++++++++
 tb/tb_hdmi_data_island_decoder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_island_pkg.sv
// Shared definitions for the HDMI data-island decoder.
// Contents: packet geometry, BCH generator polynomial, packet-type codes,
// the island state enum and the single-bit BCH LFSR step function.
package hdmi_island_pkg;

    localparam int PKT_CYCLES      = 32;
    localparam int HDR_DATA_CYCLES = 24;
    localparam int SUB_DATA_CYCLES = 28;
    localparam logic [7:0] BCH_POLY = 8'hC1;

    // Packet types carried in HB0
    localparam logic [7:0] ACR      = 8'h01;
    localparam logic [7:0] AUDIO    = 8'h02;
    localparam logic [7:0] AVI_IF   = 8'h82;
    localparam logic [7:0] AUDIO_IF = 8'h84;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_NEXT  = 2'd2
    } island_state_t;

    // One LFSR step: shift left, fold in the polynomial when the outgoing
    // MSB differs from the incoming data bit.
    function automatic logic [7:0] bch_step(input logic [7:0] code, input logic b);
        return {code[6:0], 1'b0} ^ ((code[7] ^ b) ? BCH_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/hdmi_bch8_step.sv
// Combinational BCH(8) LFSR step, one or two data bits per call.
// Ports:
//   code_in  - current LFSR contents
//   bits     - bits[0] is applied first, bits[1] second (two-bit mode only)
//   code_out - LFSR contents after the step
// Parameter TWO_BITS selects 1-bit (header) or 2-bit (subpacket) stepping.
module hdmi_bch8_step
    import hdmi_island_pkg::*;
#(
    parameter bit TWO_BITS = 1'b0
) (
    input  logic [7:0] code_in,
    input  logic [1:0] bits,
    output logic [7:0] code_out
);

    logic [7:0] after_first;

    always_comb begin
        after_first = bch_step(code_in, bits[0]);
        code_out    = TWO_BITS ? bch_step(after_first, bits[1]) : after_first;
    end

endmodule

// File: rtl/hdmi_data_island_decoder.sv
// HDMI data-island packet decoder (TERC4 already removed).
// Assembles the 24-bit header and four 56-bit subpackets over 32 pixel
// clocks, recomputes the BCH parity of each stream, checks channel-0 bit 3
// framing and publishes the packet with a one-cycle o_pkt_valid strobe.
// Ports:
//   i_pixclk, i_rst        - pixel clock, asynchronous active-high reset
//   i_data, i_d0..i_d2     - island-active flag and per-channel nibbles
//   o_pkt_valid, o_hdr,
//   o_sub                  - packet strobe and held packet contents
//   o_hdr_ecc_err,
//   o_sub_ecc_err,
//   o_frame_err            - per-packet error flags (held with the packet)
//   o_trunc                - strobe when an island ends mid-packet
//   o_hsync, o_vsync       - sync bits captured during the island
// Optional feature macro HDMI_AUDIO_EXTRACT_EN adds o_audio_valid,
// o_audio_l, o_audio_r: one sample pair per present audio subpacket.
module hdmi_data_island_decoder
    import hdmi_island_pkg::*;
(
    input  logic             i_pixclk,
    input  logic             i_rst,
    input  logic             i_data,
    input  logic [3:0]       i_d0,
    input  logic [3:0]       i_d1,
    input  logic [3:0]       i_d2,
    output logic             o_pkt_valid,
    output logic [23:0]      o_hdr,
    output logic [3:0][55:0] o_sub,
    output logic             o_hdr_ecc_err,
    output logic [3:0]       o_sub_ecc_err,
    output logic             o_frame_err,
    output logic             o_trunc,
    output logic             o_hsync,
    output logic             o_vsync
`ifdef HDMI_AUDIO_EXTRACT_EN
    ,
    output logic             o_audio_valid,
    output logic [15:0]      o_audio_l,
    output logic [15:0]      o_audio_r
`endif
);

    localparam logic [4:0] LAST_CYCLE = 5'(PKT_CYCLES - 1);
    localparam logic [4:0] HDR_END    = 5'(HDR_DATA_CYCLES);
    localparam logic [4:0] SUB_END    = 5'(SUB_DATA_CYCLES);

    island_state_t    state, state_next;
    logic [4:0]       cnt;
    logic [23:0]      hdr_acc;
    logic [7:0]       hdr_par, hdr_code, hdr_seed, hdr_code_step;
    logic [3:0][55:0] sub_acc;
    logic [7:0]       sub_par [4];
    logic [7:0]       sub_code [4];
    logic [7:0]       sub_seed [4];
    logic [7:0]       sub_code_step [4];
    logic [3:0]       sub_err_now;
    logic             hdr_err_now;
    logic             frame_acc, frame_dev;
    logic             first_cycle, commit;

    assign first_cycle = (cnt == 5'd0);
    assign commit      = i_data && (cnt == LAST_CYCLE);

    // Bit 3 of channel 0 is low only on the very first cycle of an island;
    // that cycle is sampled while the FSM is still in IDLE.
    assign frame_dev = i_d0[3] != !(first_cycle && state == ST_IDLE);

    // LFSRs restart from zero at cycle 0 rather than being cleared a cycle
    // early, so back-to-back packets need no dead cycle.
    assign hdr_seed    = first_cycle ? 8'h00 : hdr_code;
    assign hdr_err_now = {hdr_par[6:0], i_d0[2]} != hdr_code;

    hdmi_bch8_step #(.TWO_BITS(1'b0)) u_hdr_bch (
        .code_in  (hdr_seed),
        .bits     ({1'b0, i_d0[2]}),
        .code_out (hdr_code_step)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sub
            assign sub_seed[gi]    = first_cycle ? 8'h00 : sub_code[gi];
            assign sub_err_now[gi] = {sub_par[gi][5:0], i_d1[gi], i_d2[gi]} != sub_code[gi];

            hdmi_bch8_step #(.TWO_BITS(1'b1)) u_sub_bch (
                .code_in  (sub_seed[gi]),
                .bits     ({i_d2[gi], i_d1[gi]}),
                .code_out (sub_code_step[gi])
            );
        end
    endgenerate

    always_comb begin
        state_next = state;
        if (!i_data) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  state_next = ST_FIRST;
                ST_FIRST: if (cnt == LAST_CYCLE) state_next = ST_NEXT;
                ST_NEXT:  state_next = ST_NEXT;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_pixclk or posedge i_rst) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            cnt           <= 5'd0;
            hdr_acc       <= '0;
            hdr_par       <= '0;
            hdr_code      <= '0;
            sub_acc       <= '0;
            frame_acc     <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                sub_par[k]  <= '0;
                sub_code[k] <= '0;
            end
            o_pkt_valid   <= 1'b0;
            o_hdr         <= '0;
            o_sub         <= '0;
            o_hdr_ecc_err <= 1'b0;
            o_sub_ecc_err <= '0;
            o_frame_err   <= 1'b0;
            o_trunc       <= 1'b0;
            o_hsync       <= 1'b0;
            o_vsync       <= 1'b0;
        end else begin
            state       <= state_next;
            o_pkt_valid <= 1'b0;
            o_trunc     <= 1'b0;
            if (i_data) begin
                o_hsync   <= i_d0[0];
                o_vsync   <= i_d0[1];
                cnt       <= cnt + 5'd1;
                frame_acc <= (first_cycle ? 1'b0 : frame_acc) | frame_dev;
                if (cnt < HDR_END) begin
                    hdr_acc[cnt] <= i_d0[2];
                    hdr_code     <= hdr_code_step;
                end else begin
                    hdr_par <= {hdr_par[6:0], i_d0[2]};
                end
                for (int k = 0; k < 4; k++) begin
                    if (cnt < SUB_END) begin
                        sub_acc[k][{cnt, 1'b0}] <= i_d1[k];
                        sub_acc[k][{cnt, 1'b1}] <= i_d2[k];
                        sub_code[k]             <= sub_code_step[k];
                    end else begin
                        sub_par[k] <= {sub_par[k][5:0], i_d1[k], i_d2[k]};
                    end
                end
                // Final parity bits arrive on the commit cycle itself, so the
                // comparisons use the live inputs appended to the shifters.
                if (commit) begin
                    o_pkt_valid   <= 1'b1;
                    o_hdr         <= hdr_acc;
                    o_sub         <= sub_acc;
                    o_hdr_ecc_err <= hdr_err_now;
                    o_sub_ecc_err <= sub_err_now;
                    o_frame_err   <= frame_acc | frame_dev;
                end
            end else if (cnt != 5'd0) begin
                o_trunc <= 1'b1;
                cnt     <= 5'd0;
            end
        end
    end

`ifdef HDMI_AUDIO_EXTRACT_EN
    logic [3:0] aud_pending;
    logic [1:0] aud_k;

    // Lowest pending subpacket goes first.
    always_comb begin
        aud_k = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (aud_pending[k]) aud_k = 2'(k);
        end
    end

    always_ff @(posedge i_pixclk or posedge i_rst) begin
        if (i_rst) begin
            aud_pending   <= '0;
            o_audio_valid <= 1'b0;
            o_audio_l     <= '0;
            o_audio_r     <= '0;
        end else begin
            o_audio_valid <= 1'b0;
            if (commit) begin
                aud_pending <= (hdr_acc[7:0] == AUDIO && !hdr_err_now && sub_err_now == 4'b0000)
                               ? hdr_acc[11:8] : 4'b0000;
            end else if (aud_pending != 4'b0000) begin
                o_audio_valid      <= 1'b1;
                o_audio_l          <= o_sub[aud_k][23:8];
                o_audio_r          <= o_sub[aud_k][47:32];
                aud_pending[aud_k] <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hdmi_data_island_decoder.sv
// Self-checking bench for hdmi_data_island_decoder: a table of packets with
// optional single-bit corruptions, then hand-written sequences for
// truncation, back-to-back framing, audio extraction and mid-packet reset.
module tb_hdmi_data_island_decoder;

    logic             i_pixclk = 1'b0;
    logic             i_rst;
    logic             i_data;
    logic [3:0]       i_d0, i_d1, i_d2;
    logic             o_pkt_valid;
    logic [23:0]      o_hdr;
    logic [3:0][55:0] o_sub;
    logic             o_hdr_ecc_err;
    logic [3:0]       o_sub_ecc_err;
    logic             o_frame_err, o_trunc, o_hsync, o_vsync;
`ifdef HDMI_AUDIO_EXTRACT_EN
    logic             o_audio_valid;
    logic [15:0]      o_audio_l, o_audio_r;
`endif

    hdmi_data_island_decoder dut (
        .i_pixclk      (i_pixclk),
        .i_rst         (i_rst),
        .i_data        (i_data),
        .i_d0          (i_d0),
        .i_d1          (i_d1),
        .i_d2          (i_d2),
        .o_pkt_valid   (o_pkt_valid),
        .o_hdr         (o_hdr),
        .o_sub         (o_sub),
        .o_hdr_ecc_err (o_hdr_ecc_err),
        .o_sub_ecc_err (o_sub_ecc_err),
        .o_frame_err   (o_frame_err),
        .o_trunc       (o_trunc),
        .o_hsync       (o_hsync),
        .o_vsync       (o_vsync)
`ifdef HDMI_AUDIO_EXTRACT_EN
        ,
        .o_audio_valid (o_audio_valid),
        .o_audio_l     (o_audio_l),
        .o_audio_r     (o_audio_r)
`endif
    );

    always #5 i_pixclk = ~i_pixclk;

    int cyc = 0;
    always @(posedge i_pixclk) cyc <= cyc + 1;

    int pass_cnt = 0;
    int total    = 0;

    task automatic check(input string name, input logic [223:0] act, input logic [223:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Strobe monitor, sampled on the falling edge.
    int   pv_count = 0, pv_last = -1, pv_prev = -1, trunc_count = 0;
    logic pv_frame_last = 1'b0, pv_frame_prev = 1'b0;
`ifdef HDMI_AUDIO_EXTRACT_EN
    int          aud_cyc [$];
    logic [15:0] aud_l [$];
    logic [15:0] aud_r [$];
`endif
    always @(negedge i_pixclk) begin
        if (o_pkt_valid === 1'b1) begin
            pv_prev       = pv_last;
            pv_frame_prev = pv_frame_last;
            pv_last       = cyc;
            pv_frame_last = o_frame_err;
            pv_count++;
        end
        if (o_trunc === 1'b1) trunc_count++;
`ifdef HDMI_AUDIO_EXTRACT_EN
        if (o_audio_valid === 1'b1) begin
            aud_cyc.push_back(cyc);
            aud_l.push_back(o_audio_l);
            aud_r.push_back(o_audio_r);
        end
`endif
    end

    function automatic logic [7:0] bch(input logic [55:0] bits, input int n);
        logic [7:0] code;
        logic       fb;
        code = 8'h00;
        for (int i = 0; i < n; i++) begin
            fb   = code[7] ^ bits[i];
            code = {code[6:0], 1'b0} ^ (fb ? 8'hC1 : 8'h00);
        end
        return code;
    endfunction

    // Per-cycle nibbles of the packet currently being sent.
    logic [3:0] pd0 [32];
    logic [3:0] pd1 [32];
    logic [3:0] pd2 [32];

    task automatic build(input logic [23:0] hdr, input logic [3:0][55:0] sub, input bit first);
        logic [7:0] hpar;
        logic [7:0] spar [4];
        hpar = bch({32'h0, hdr}, 24);
        for (int k = 0; k < 4; k++) spar[k] = bch(sub[k], 56);
        for (int c = 0; c < 32; c++) begin
            pd0[c][0] = c[0];
            pd0[c][1] = ~c[0];
            pd0[c][2] = (c < 24) ? hdr[c] : hpar[31 - c];
            pd0[c][3] = (first && c == 0) ? 1'b0 : 1'b1;
            for (int k = 0; k < 4; k++) begin
                pd1[c][k] = (c < 28) ? sub[k][2*c]     : spar[k][7 - 2*(c-28)];
                pd2[c][k] = (c < 28) ? sub[k][2*c + 1] : spar[k][6 - 2*(c-28)];
            end
        end
    endtask

    task automatic send(input int ncyc, output int last_cyc);
        for (int c = 0; c < ncyc; c++) begin
            i_data = 1'b1;
            i_d0 = pd0[c]; i_d1 = pd1[c]; i_d2 = pd2[c];
            @(posedge i_pixclk); #1;
        end
        last_cyc = cyc;
    endtask

    task automatic idle(input int n);
        i_data = 1'b0; i_d0 = '0; i_d1 = '0; i_d2 = '0;
        repeat (n) begin @(posedge i_pixclk); #1; end
    endtask

    typedef struct {
        logic [23:0]      hdr;
        logic [3:0][55:0] sub;
        int               flip_hdr;
        int               flip_k;
        int               flip_b;
        logic             exp_hdr_err;
        logic [3:0]       exp_sub_err;
    } vec_t;

    localparam logic [55:0] ACR_SUB = 56'h00_0000_6069_0018_00;

    initial begin
        vec_t             vecs [6];
        vec_t             v;
        logic [23:0]      exp_hdr;
        logic [3:0][55:0] exp_sub;
        logic [3:0][55:0] s;
        int               last, pv0, tr0, c;

        vecs[0] = '{24'h000001, {4{ACR_SUB}}, -1, -1, 0, 1'b0, 4'b0000};
        vecs[1] = '{24'h000001, {4{ACR_SUB}},  5, -1, 0, 1'b1, 4'b0000};
        vecs[2] = '{24'h000001, {4{ACR_SUB}}, -1,  2, 40, 1'b0, 4'b0100};
        vecs[3] = '{24'h5AC384, {56'hFFFFFFFFFFFFFF, 56'h0, 56'hFEDCBA98765432, 56'h0123456789ABCD},
                    -1, -1, 0, 1'b0, 4'b0000};
        vecs[4] = '{24'hFFFF82, {56'hA5A5A5A5A5A5A5, 56'h5A5A5A5A5A5A5A, 56'h0F0F0F0F0F0F0F, 56'hF0F0F0F0F0F0F0},
                    -1,  3, 55, 1'b0, 4'b1000};
        vecs[5] = '{24'h000001, {4{ACR_SUB}}, 23,  0, 0, 1'b1, 4'b0001};

        i_rst = 1'b0; i_data = 1'b0; i_d0 = '0; i_d1 = '0; i_d2 = '0;
        #1 i_rst = 1'b1;
        #1;
        check("reset pkt_valid", o_pkt_valid, 1'b0);
        check("reset hdr", o_hdr, 24'h0);
        check("reset sub", o_sub, '0);
        check("reset errs", {o_hdr_ecc_err, o_sub_ecc_err, o_frame_err, o_trunc}, 7'h0);
        #10 i_rst = 1'b0;
        @(posedge i_pixclk); #1;
        idle(2);

        exp_hdr = '0; exp_sub = '0;
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            build(v.hdr, v.sub, 1'b1);
            exp_hdr = v.hdr;
            exp_sub = v.sub;
            if (v.flip_hdr >= 0) begin
                pd0[v.flip_hdr][2] = ~pd0[v.flip_hdr][2];
                exp_hdr[v.flip_hdr] = ~exp_hdr[v.flip_hdr];
            end
            if (v.flip_k >= 0) begin
                c = v.flip_b / 2;
                if (v.flip_b % 2 == 0) pd1[c][v.flip_k] = ~pd1[c][v.flip_k];
                else                   pd2[c][v.flip_k] = ~pd2[c][v.flip_k];
                exp_sub[v.flip_k][v.flip_b] = ~exp_sub[v.flip_k][v.flip_b];
            end
            pv0 = pv_count; tr0 = trunc_count;
            send(32, last);
            idle(2);
            check($sformatf("v%0d pkt count", i), pv_count - pv0, 1);
            check($sformatf("v%0d pkt timing", i), pv_last, last);
            check($sformatf("v%0d hdr", i), o_hdr, exp_hdr);
            check($sformatf("v%0d sub", i), o_sub, exp_sub);
            check($sformatf("v%0d hdr_ecc_err", i), o_hdr_ecc_err, v.exp_hdr_err);
            check($sformatf("v%0d sub_ecc_err", i), o_sub_ecc_err, v.exp_sub_err);
            check($sformatf("v%0d frame_err", i), o_frame_err, 1'b0);
            check($sformatf("v%0d clean end no trunc", i), trunc_count - tr0, 0);
            check($sformatf("v%0d hsync/vsync", i), {o_hsync, o_vsync}, 2'b10);
        end

        // Island ends at cycle 15: trunc strobe, packet dropped, outputs held.
        build(24'h000084, {4{56'h11223344556677}}, 1'b1);
        pv0 = pv_count; tr0 = trunc_count;
        send(15, last);
        idle(3);
        check("trunc pulse", trunc_count - tr0, 1);
        check("trunc no pkt", pv_count - pv0, 0);
        check("trunc hdr held", o_hdr, exp_hdr);
        check("trunc sub held", o_sub, exp_sub);
        check("trunc err held", {o_hdr_ecc_err, o_sub_ecc_err}, {vecs[5].exp_hdr_err, vecs[5].exp_sub_err});

        // Back-to-back: second packet wrongly marks itself as island start.
        build(24'h000001, {4{ACR_SUB}}, 1'b1);
        pv0 = pv_count;
        send(32, last);
        build(24'h000084, {4{56'h11223344556677}}, 1'b0);
        pd0[0][3] = 1'b0;
        send(32, last);
        idle(2);
        check("b2b pkt count", pv_count - pv0, 2);
        check("b2b spacing", pv_last - pv_prev, 32);
        check("b2b first frame_err", pv_frame_prev, 1'b0);
        check("b2b second frame_err", pv_frame_last, 1'b1);
        check("b2b second hdr", o_hdr, 24'h000084);
        check("b2b second sub", o_sub, {4{56'h11223344556677}});
        check("b2b second ecc", {o_hdr_ecc_err, o_sub_ecc_err}, 5'h0);

`ifdef HDMI_AUDIO_EXTRACT_EN
        s = {56'h0, 56'h0, 56'h00FFFF00000100, 56'h00ABCD00123400};
        build(24'h000302, s, 1'b1);
        aud_cyc.delete(); aud_l.delete(); aud_r.delete();
        send(32, last);
        idle(6);
        check("audio count", aud_cyc.size(), 2);
        if (aud_cyc.size() >= 2) begin
            check("audio0 timing", aud_cyc[0], last + 1);
            check("audio0 pair", {aud_l[0], aud_r[0]}, 32'h1234ABCD);
            check("audio1 timing", aud_cyc[1], last + 2);
            check("audio1 pair", {aud_l[1], aud_r[1]}, 32'h0001FFFF);
        end
`else
        build(24'h000001, {4{ACR_SUB}}, 1'b1);
        send(32, last);
        idle(2);
`endif

        // Reset asserted during cycle 10 of the following packet.
        build(24'h000084, {4{56'h11223344556677}}, 1'b1);
        pv0 = pv_count; tr0 = trunc_count;
        send(10, last);
        i_data = 1'b1; i_d0 = pd0[10]; i_d1 = pd1[10]; i_d2 = pd2[10];
        check("pre-reset hsync", o_hsync, 1'b1);
        #2 i_rst = 1'b1;
        #1;
        check("midreset pkt_valid", o_pkt_valid, 1'b0);
        check("midreset hdr", o_hdr, 24'h0);
        check("midreset sub", o_sub, '0);
        check("midreset flags", {o_hdr_ecc_err, o_sub_ecc_err, o_frame_err, o_trunc, o_hsync, o_vsync}, 9'h0);
`ifdef HDMI_AUDIO_EXTRACT_EN
        check("midreset audio", {o_audio_valid, o_audio_l, o_audio_r}, 33'h0);
`endif
        i_data = 1'b0;
        @(posedge i_pixclk); #1;
        i_rst = 1'b0;
        idle(2);
        s = {56'h00000000000001, 56'h80000000000000, 56'h13579BDF02468A, 56'hCAFEF00DBEEF42};
        build(24'h123401, s, 1'b1);
        send(32, last);
        idle(2);
        check("post-reset pkt count", pv_count - pv0, 1);
        check("post-reset timing", pv_last, last);
        check("post-reset no trunc", trunc_count - tr0, 0);
        check("post-reset hdr", o_hdr, 24'h123401);
        check("post-reset sub", o_sub, s);
        check("post-reset errs", {o_hdr_ecc_err, o_sub_ecc_err, o_frame_err}, 6'h0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
